// File: rtl/memory_pkg.sv
// Shared types and helpers for the byte-writable true dual-port buffer.
package memory_pkg;

    localparam int unsigned RDW_WRITE_FIRST = 0;
    localparam int unsigned RDW_READ_FIRST  = 1;

    // Widest word the lane-merge helper handles; callers zero-extend into it.
    localparam int unsigned MERGE_MAX_W = 256;
    localparam int unsigned MERGE_IDX_W = $clog2(MERGE_MAX_W);

    typedef enum logic {
        CLEAR,
        READY
    } mem_state_e;

    // Replace the lanes of old_word selected by be with the matching lanes of new_data.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_data,
        input logic [MERGE_MAX_W-1:0] be,
        input int unsigned            byte_w
    );
        logic [MERGE_MAX_W-1:0] w;
        for (int unsigned i = 0; i < MERGE_MAX_W; i++) begin
            w[MERGE_IDX_W'(i)] = be[MERGE_IDX_W'(i / byte_w)] ? new_data[MERGE_IDX_W'(i)]
                                                               : old_word[MERGE_IDX_W'(i)];
        end
        return w;
    endfunction

endpackage

// File: rtl/memory_read_pipe.sv
// Per-port read output stage: pass-through, one register, or two registers.
module memory_read_pipe #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] q
);

    generate
        if (READ_LATENCY == 0) begin : g_comb
            logic unused_ok;
            assign unused_ok = flush ^ CLK;
            assign q = rd_data;
        end else if (READ_LATENCY == 1) begin : g_one
            logic [DATA_WIDTH-1:0] s1_q;
            always_ff @(posedge CLK) begin
                if (flush) s1_q <= '0;
                else       s1_q <= rd_data;
            end
            assign q = s1_q;
        end else begin : g_two
            logic [DATA_WIDTH-1:0] s1_q;
            logic [DATA_WIDTH-1:0] s2_q;
            // Flush empties both stages so no stale word emerges after a clear.
            always_ff @(posedge CLK) begin
                if (flush) begin
                    s1_q <= '0;
                    s2_q <= '0;
                end else begin
                    s1_q <= rd_data;
                    s2_q <= s1_q;
                end
            end
            assign q = s2_q;
        end
    endgenerate

endmodule

// File: rtl/memory_tdp_bytewise.sv
// Single-clock true dual-port RAM with byte enables, selectable read latency,
// read-during-write policy, collision flag and a self-clearing sequencer.
module memory_tdp_bytewise
    import memory_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           BYTE_WIDTH   = 8,
    parameter int unsigned           BUFFER_SIZE  = 8,
    parameter int unsigned           ADDR_SIZE    = $clog2(BUFFER_SIZE),
    parameter int unsigned           READ_LATENCY = 1,
    parameter int unsigned           RDW_MODE     = RDW_WRITE_FIRST,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               CLR,
    input  logic [ADDR_SIZE-1:0]               A1,
    input  logic                               WEN1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   BE1,
    input  logic [DATA_WIDTH-1:0]              D1,
    output logic [DATA_WIDTH-1:0]              Q1,
    input  logic [ADDR_SIZE-1:0]               A2,
    input  logic                               WEN2,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   BE2,
    input  logic [DATA_WIDTH-1:0]              D2,
    output logic [DATA_WIDTH-1:0]              Q2,
    output logic                               BUSY,
    output logic                               COLLISION
);

    localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(BUFFER_SIZE - 1);

    logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

    mem_state_e           state_q, state_n;
    logic [ADDR_SIZE-1:0] cnt_q, cnt_n;
    logic                 busy_q;
    logic                 coll_q;

    logic                  ready_c;
    logic                  in1_c, in2_c;
    logic                  we1_c, we2_c;
    logic                  same_c;
    logic                  pipe_flush_c;
    logic [DATA_WIDTH-1:0] old1_c, old2_c;
    logic [DATA_WIDTH-1:0] new1_c, new2_c;
    logic [DATA_WIDTH-1:0] rd1_c, rd2_c;

    function automatic logic [DATA_WIDTH-1:0] merge_word(
        input logic [DATA_WIDTH-1:0] w,
        input logic [DATA_WIDTH-1:0] d,
        input logic [NB-1:0]         be
    );
        return DATA_WIDTH'(lane_merge(MERGE_MAX_W'(w), MERGE_MAX_W'(d), MERGE_MAX_W'(be),
                                      BYTE_WIDTH));
    endfunction

    // Sequencer state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            busy_q  <= (state_n == CLEAR);
        end
    end

    // Sequencer next state: walk every word once, then serve the ports
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_ADDR) state_n = READY;
                else                    cnt_n   = cnt_q + ADDR_SIZE'(1);
            end
            READY: begin
                if (CLR) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    assign ready_c = (state_q == READY);
    assign in1_c   = 32'(A1) < BUFFER_SIZE;
    assign in2_c   = 32'(A2) < BUFFER_SIZE;
    assign we1_c   = WEN1 & in1_c & ready_c;
    assign we2_c   = WEN2 & in2_c & ready_c;
    assign same_c  = (A1 == A2);

    // Post-write word at each port address; port 1 merged last so it owns shared lanes
    always_comb begin
        old1_c = in1_c ? mem[A1] : '0;
        old2_c = in2_c ? mem[A2] : '0;
        new1_c = old1_c;
        new2_c = old2_c;
        if (we2_c && same_c) new1_c = merge_word(new1_c, D2, BE2);
        if (we1_c)           new1_c = merge_word(new1_c, D1, BE1);
        if (we2_c)           new2_c = merge_word(new2_c, D2, BE2);
        if (we1_c && same_c) new2_c = merge_word(new2_c, D1, BE1);
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state_q == CLEAR) begin
                mem[cnt_q] <= CLEAR_VALUE;
            end else begin
                if (we2_c) mem[A2] <= new2_c;
                if (we1_c) mem[A1] <= new1_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) coll_q <= 1'b0;
        else     coll_q <= ready_c & WEN1 & WEN2 & same_c & (|(BE1 & BE2));
    end

    // Read source per latency and read-during-write policy
    always_comb begin
        if (READ_LATENCY == 0) begin
            rd1_c = ready_c ? old1_c : '0;
            rd2_c = ready_c ? old2_c : '0;
        end else if (RDW_MODE == RDW_READ_FIRST) begin
            rd1_c = old1_c;
            rd2_c = old2_c;
        end else begin
            rd1_c = new1_c;
            rd2_c = new2_c;
        end
    end

    assign pipe_flush_c = RST | (state_q == CLEAR) | (ready_c & CLR);

    memory_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe1 (
        .CLK    (CLK),
        .flush  (pipe_flush_c),
        .rd_data(rd1_c),
        .q      (Q1)
    );

    memory_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe2 (
        .CLK    (CLK),
        .flush  (pipe_flush_c),
        .rd_data(rd2_c),
        .q      (Q2)
    );

    assign BUSY      = busy_q;
    assign COLLISION = coll_q;

endmodule

// File: tb/tb_memory_tdp_bytewise.sv
// Randomized bench for memory_tdp_bytewise across latency, RDW and size variants.
module tb_memory_tdp_bytewise;

    localparam int unsigned NI = 5;

    logic        CLK;
    logic        rst, clr;
    logic [2:0]  a1, a2;
    logic        wen1, wen2;
    logic [3:0]  be1, be2;
    logic [31:0] d1, d2;
    logic [31:0] q1 [NI];
    logic [31:0] q2 [NI];
    logic        busy [NI];
    logic        coll [NI];

    // Variant table: instance k has latency lat[k], read-first if rdw[k], size[k] words
    int unsigned lat  [NI] = '{0, 1, 1, 2, 1};
    int unsigned rdw  [NI] = '{0, 0, 1, 0, 0};
    int unsigned size [NI] = '{8, 8, 8, 8, 6};

    logic [31:0] mm   [NI][8];
    bit          rdy  [NI];
    int unsigned ccnt [NI];
    bit          mcoll[NI];
    logic [31:0] p1s1 [NI];
    logic [31:0] p1s2 [NI];
    logic [31:0] p2s1 [NI];
    logic [31:0] p2s2 [NI];

    int n_checks;
    int n_fail;
    int blen;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    memory_tdp_bytewise #(.READ_LATENCY(0), .RDW_MODE(0), .BUFFER_SIZE(8)) u_l0 (
        .CLK(CLK), .RST(rst), .CLR(clr),
        .A1(a1), .WEN1(wen1), .BE1(be1), .D1(d1), .Q1(q1[0]),
        .A2(a2), .WEN2(wen2), .BE2(be2), .D2(d2), .Q2(q2[0]),
        .BUSY(busy[0]), .COLLISION(coll[0]));

    memory_tdp_bytewise #(.READ_LATENCY(1), .RDW_MODE(0), .BUFFER_SIZE(8)) u_l1_wf (
        .CLK(CLK), .RST(rst), .CLR(clr),
        .A1(a1), .WEN1(wen1), .BE1(be1), .D1(d1), .Q1(q1[1]),
        .A2(a2), .WEN2(wen2), .BE2(be2), .D2(d2), .Q2(q2[1]),
        .BUSY(busy[1]), .COLLISION(coll[1]));

    memory_tdp_bytewise #(.READ_LATENCY(1), .RDW_MODE(1), .BUFFER_SIZE(8)) u_l1_rf (
        .CLK(CLK), .RST(rst), .CLR(clr),
        .A1(a1), .WEN1(wen1), .BE1(be1), .D1(d1), .Q1(q1[2]),
        .A2(a2), .WEN2(wen2), .BE2(be2), .D2(d2), .Q2(q2[2]),
        .BUSY(busy[2]), .COLLISION(coll[2]));

    memory_tdp_bytewise #(.READ_LATENCY(2), .RDW_MODE(0), .BUFFER_SIZE(8)) u_l2 (
        .CLK(CLK), .RST(rst), .CLR(clr),
        .A1(a1), .WEN1(wen1), .BE1(be1), .D1(d1), .Q1(q1[3]),
        .A2(a2), .WEN2(wen2), .BE2(be2), .D2(d2), .Q2(q2[3]),
        .BUSY(busy[3]), .COLLISION(coll[3]));

    memory_tdp_bytewise #(.READ_LATENCY(1), .RDW_MODE(0), .BUFFER_SIZE(6)) u_s6 (
        .CLK(CLK), .RST(rst), .CLR(clr),
        .A1(a1), .WEN1(wen1), .BE1(be1), .D1(d1), .Q1(q1[4]),
        .A2(a2), .WEN2(wen2), .BE2(be2), .D2(d2), .Q2(q2[4]),
        .BUSY(busy[4]), .COLLISION(coll[4]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_word(input int k, input logic [2:0] a);
        return (32'(a) < size[k]) ? mm[k][a] : 32'h0;
    endfunction

    task automatic mem_write(input int k, input logic [2:0] a, input logic [3:0] be,
                             input logic [31:0] d);
        if (32'(a) >= size[k]) return;
        for (int i = 0; i < 4; i++)
            if (be[i]) mm[k][a][8*i +: 8] = d[8*i +: 8];
    endtask

    // Reference behaviour of every instance for the coming rising edge
    task automatic model_edge();
        for (int k = 0; k < int'(NI); k++) begin
            logic [31:0] o1, o2, n1, n2;
            bit flush;
            o1 = rd_word(k, a1);
            o2 = rd_word(k, a2);
            flush = 1'b1;
            if (rst) begin
                rdy[k] = 1'b0; ccnt[k] = 0; mcoll[k] = 1'b0;
            end else if (!rdy[k]) begin
                mm[k][ccnt[k]] = 32'h0;
                if (ccnt[k] == size[k] - 1) rdy[k] = 1'b1;
                else                        ccnt[k]++;
                mcoll[k] = 1'b0;
            end else begin
                if (wen2) mem_write(k, a2, be2, d2);
                if (wen1) mem_write(k, a1, be1, d1);
                mcoll[k] = wen1 && wen2 && (a1 == a2) && ((be1 & be2) != 4'b0);
                flush = clr;
                if (clr) begin rdy[k] = 1'b0; ccnt[k] = 0; end
            end
            n1 = rd_word(k, a1);
            n2 = rd_word(k, a2);
            p1s2[k] = flush ? 32'h0 : p1s1[k];
            p1s1[k] = flush ? 32'h0 : (rdw[k] != 0 ? o1 : n1);
            p2s2[k] = flush ? 32'h0 : p2s1[k];
            p2s1[k] = flush ? 32'h0 : (rdw[k] != 0 ? o2 : n2);
        end
    endtask

    function automatic logic [31:0] exp_q(input int k, input logic [2:0] a,
                                          input logic [31:0] s1, input logic [31:0] s2);
        if (lat[k] == 0) return rdy[k] ? rd_word(k, a) : 32'h0;
        if (lat[k] == 1) return s1;
        return s2;
    endfunction

    task automatic check_all();
        for (int k = 0; k < int'(NI); k++) begin
            check_eq($sformatf("busy[%0d]", k), 32'(busy[k]), 32'(!rdy[k]));
            check_eq($sformatf("coll[%0d]", k), 32'(coll[k]), 32'(mcoll[k]));
            check_eq($sformatf("q1[%0d]", k), q1[k], exp_q(k, a1, p1s1[k], p1s2[k]));
            check_eq($sformatf("q2[%0d]", k), q2[k], exp_q(k, a2, p2s1[k], p2s2[k]));
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic idle();
        clr = 1'b0; wen1 = 1'b0; wen2 = 1'b0;
        be1 = 4'h0; be2 = 4'h0; d1 = 32'h0; d2 = 32'h0;
    endtask

    task automatic rand_inputs(input int addr_max);
        clr  = 1'b0;
        a1   = 3'($urandom_range(0, addr_max));
        a2   = 3'($urandom_range(0, addr_max));
        wen1 = 1'($urandom_range(0, 1));
        wen2 = 1'($urandom_range(0, 1));
        be1  = 4'($urandom);
        be2  = 4'($urandom);
        d1   = $urandom;
        d2   = $urandom;
    endtask

    task automatic wr1(input logic [2:0] a, input logic [3:0] be, input logic [31:0] d);
        idle();
        a1 = a; wen1 = 1'b1; be1 = be; d1 = d;
        step();
    endtask

    // Count cycles BUSY stays high after RST is released, with random traffic
    task automatic busy_run(input string tag);
        rst = 1'b0;
        blen = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy[0]) break;
            blen++;
            rand_inputs(7);
            step();
        end
        check_eq(tag, 32'(blen), 32'd8);
    endtask

    task automatic zero_sweep(input string tag);
        idle();
        for (int i = 0; i < 8; i++) begin
            a1 = 3'(i); a2 = 3'(7 - i);
            step();
            check_eq({tag, "_p1"}, q1[1], 32'h0);
            check_eq({tag, "_p2"}, q2[2], 32'h0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < int'(NI); k++) begin
            rdy[k] = 1'b0; ccnt[k] = 0; mcoll[k] = 1'b0;
            p1s1[k] = 32'h0; p1s2[k] = 32'h0; p2s1[k] = 32'h0; p2s2[k] = 32'h0;
            for (int j = 0; j < 8; j++) mm[k][j] = 32'h0;
        end
        rst = 1'b1; a1 = 3'd0; a2 = 3'd0;
        idle();
        @(negedge CLK);
        repeat (3) step();

        busy_run("busy_len_reset");
        zero_sweep("clear_word");

        // Byte-lane write
        wr1(3'd0, 4'b0101, 32'hAABB_CCDD);
        idle(); a1 = 3'd0;
        step();
        check_eq("byte_write", q1[1], 32'h00BB_00DD);

        // Overlapping writes to one address: port 1 owns lane 1
        idle();
        a1 = 3'd3; wen1 = 1'b1; be1 = 4'b0011; d1 = 32'h1111_1111;
        a2 = 3'd3; wen2 = 1'b1; be2 = 4'b0110; d2 = 32'h2222_2222;
        step();
        check_eq("coll_high", 32'(coll[1]), 32'd1);
        idle(); a1 = 3'd3;
        step();
        check_eq("coll_low", 32'(coll[1]), 32'd0);
        check_eq("coll_word", q1[1], 32'h0022_1111);

        // Read during write on the same and the other port
        wr1(3'd2, 4'hF, 32'h5);
        idle();
        a1 = 3'd2; wen1 = 1'b1; be1 = 4'hF; d1 = 32'h9; a2 = 3'd2;
        step();
        check_eq("rdw_wf_p1", q1[1], 32'h9);
        check_eq("rdw_rf_p1", q1[2], 32'h5);
        check_eq("rdw_wf_p2", q2[1], 32'h9);
        check_eq("rdw_rf_p2", q2[2], 32'h5);

        // Latency sweep over known words
        wr1(3'd4, 4'hF, 32'hA4A4_A4A4);
        wr1(3'd5, 4'hF, 32'hA5A5_A5A5);
        wr1(3'd6, 4'hF, 32'hA6A6_A6A6);
        idle();
        a1 = 3'd4; step();
        a1 = 3'd5; step();
        check_eq("lat0", q1[0], 32'hA5A5_A5A5);
        check_eq("lat1", q1[1], 32'hA5A5_A5A5);
        check_eq("lat2", q1[3], 32'hA4A4_A4A4);
        a1 = 3'd6; step();
        check_eq("lat2_next", q1[3], 32'hA5A5_A5A5);
        step();

        // Random traffic, narrow address range stresses collisions
        for (int i = 0; i < 200; i++) begin
            rand_inputs(($urandom_range(0, 1) != 0) ? 3 : 7);
            step();
        end

        // Clear request mid-traffic, then reset at clear count 4
        rand_inputs(7); clr = 1'b1;
        step();
        repeat (4) begin rand_inputs(7); step(); end
        check_eq("busy_mid_clear", 32'(busy[0]), 32'd1);
        rand_inputs(7); rst = 1'b1;
        step();
        busy_run("busy_len_restart");
        zero_sweep("restart_word");

        // Random traffic with occasional clear requests
        for (int i = 0; i < 150; i++) begin
            rand_inputs(($urandom_range(0, 1) != 0) ? 3 : 7);
            clr = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_tdp_bytewise.md
# memory_tdp_bytewise

Parametrised true dual-port, single-clock RAM for the number-converter datapath buffers. Extends the plain dual-port buffer with per-byte write enables, selectable read latency (0/1/2), a defined read-during-write policy, deterministic write-collision resolution with a flag, and a self-clearing sequencer that walks the array after reset or on request. Used wherever converter stages share coefficient or staging buffers and need a known-zero state without external initialisation.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, width of one write-enable lane
- BUFFER_SIZE, 8, number of words
- ADDR_SIZE, $clog2(BUFFER_SIZE), address width
- NB, DATA_WIDTH/BYTE_WIDTH, byte lanes (derived, not overridden)
- READ_LATENCY, 1, 0 = combinational read, 1 = registered, 2 = registered plus output register
- RDW_MODE, 0, 0 = write-first, 1 = read-first (applies when READ_LATENCY ≥ 1)
- CLEAR_VALUE, 0, word written by the clear sequencer

- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- CLR  in  1  start clear sequence (one-cycle pulse, sampled when idle)
- A1  in  ADDR_SIZE  port 1 address
- WEN1  in  1  port 1 write enable
- BE1  in  NB  port 1 byte enables
- D1  in  DATA_WIDTH  port 1 write data
- Q1  out  DATA_WIDTH  port 1 read data
- A2, WEN2, BE2, D2, Q2  same as port 1, for port 2
- BUSY  out  1  clear in progress; port writes ignored
- COLLISION  out  1  pulse: both ports wrote overlapping bytes of one address

## Operation
- States: CLEAR, READY. RST=1 forces CLEAR, clear counter 0, pipeline registers 0, COLLISION 0, BUSY 1.
- CLEAR: each edge with RST=0 writes CLEAR_VALUE (all lanes) at counter, counter increments; after writing BUFFER_SIZE-1 → READY. Port writes dropped. Q1/Q2 forced to 0.
- READY: CLR=1 → CLEAR with counter 0. CLR during CLEAR ignored. RST during CLEAR restarts at 0.
- Write: lane i of data[Ax] updated from Dx[i] when WENx & BEx[i] & READY. BEx=0 with WENx=1 is a no-op.
- Collision: WEN1 & WEN2 & A1==A2 & (BE1 & BE2)≠0 → port 1 wins overlapping lanes; non-overlapping lanes from each port's own data. COLLISION=1 the cycle after, for one cycle.
- Read: READ_LATENCY=0 → Qx = data[Ax] combinationally. ≥1 → read registered on each edge (no read enable).
- RDW (same or cross port, same address, latency ≥1): write-first returns the post-write word (including collision resolution and byte merge); read-first returns the pre-write word.
- BUFFER_SIZE not a power of two: addresses ≥ BUFFER_SIZE ignore writes, read 0.

## Timing
- Reset values: Q1=Q2=0, BUSY=1, COLLISION=0.
- Clear: BUSY=1 during RST and for exactly BUFFER_SIZE cycles after the first edge with RST=0 (or after the CLR edge); first port write accepted on the edge where BUSY is first 0.
- Read latency: address at edge n → Qx valid after edge n+READ_LATENCY (latency 0: same cycle).
- Write visible to reads issued on the following edge (all modes); RDW as above.
- COLLISION: flagged cycle n writes → COLLISION high during cycle n+1 only.

## Structure
- Package memory_pkg: RDW_WRITE_FIRST/RDW_READ_FIRST constants, state enum (CLEAR, READY), lane-merge function (old word, new data, byte-enable mask).
- One sub-module natural: memory_read_pipe (0/1/2-stage output register, reset to 0, instantiated per port).
- Clear sequencer and collision logic inline in the top.

## Test plan
- Reset release, BUFFER_SIZE=8 → BUSY high exactly 8 cycles; all words read 0x0000_0000; writes issued while BUSY have no effect.
- Byte write: D1=0xAABBCCDD, BE1=4'b0101 to word 0x00000000 → reads 0x00BB00DD.
- Collision at A=3: D1=0x11111111 BE1=4'b0011, D2=0x22222222 BE2=4'b0110 → word 0x00221111, COLLISION high one cycle.
- RDW, READ_LATENCY=1: word 0x5 at A=2, write 0x9 at A=2 while reading A=2 → Q=0x9 (RDW_MODE=0), Q=0x5 (RDW_MODE=1).
- Latency sweep 0/1/2: address step 0→1→2 with known contents → Q follows after 0/1/2 edges.
- CLR pulse mid-traffic, then RST asserted at clear count 4 → sequencer restarts, BUSY lasts 8 cycles after RST release, memory all CLEAR_VALUE.
